// File: rtl/lamp_pkg.sv
// Shared LED-lamp definitions: board geometry, sizing helpers and the
// framebuffer swap controller state encoding.
package lamp_pkg;

  localparam int unsigned c_leds_per_board = 32;

  typedef enum logic [1:0] {
    ST_CLEAR   = 2'd0,
    ST_WRITE   = 2'd1,
    ST_PENDING = 2'd2
  } swap_state_e;

  function automatic int unsigned lamp_channels(input int unsigned ledboards);
    return ledboards * c_leds_per_board;
  endfunction

  function automatic int unsigned lamp_addr_w(input int unsigned channels);
    return $clog2(channels);
  endfunction

endpackage

// File: rtl/fb_swap_ctrl.sv
// Double-buffer controller: steers source writes to the back bank, reads to
// the front bank, and swaps banks on the driver's frame request after commit.
module fb_swap_ctrl
  import lamp_pkg::*;
#(
  parameter int unsigned  c_ledboards = 2,
  parameter int unsigned  c_bps       = 12,
  localparam int unsigned c_channels  = lamp_channels(c_ledboards),
  localparam int unsigned c_addr_w    = lamp_addr_w(c_channels)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_wr_valid,
  output logic                o_wr_ready,
  input  logic [c_addr_w-1:0] i_wr_addr,
  input  logic [c_bps-1:0]    i_wr_data,
  input  logic                i_commit,
  output logic                o_pending,
  input  logic                i_drv_drq,
  input  logic                i_drv_read,
  input  logic [c_addr_w-1:0] i_drv_addr,
  output logic                o_mem_wen,
  output logic [c_addr_w:0]   o_mem_waddr,
  output logic [c_bps-1:0]    o_mem_wdata,
  output logic                o_mem_ren,
  output logic [c_addr_w:0]   o_mem_raddr,
  output logic                o_swap,
  output logic [7:0]          o_frames
);

  localparam logic [c_addr_w:0] c_chan = (c_addr_w+1)'(c_channels);
  localparam logic [c_addr_w:0] c_last = (c_addr_w+1)'(2*c_channels-1);
  localparam logic [c_addr_w:0] c_one  = (c_addr_w+1)'(1);

  swap_state_e         state_q, state_d;
  logic                front_q, front_d;
  logic [c_addr_w:0]   cnt_q, cnt_d;
  logic                mem_wen_q, mem_wen_d;
  logic [c_addr_w:0]   mem_waddr_q, mem_waddr_d;
  logic [c_bps-1:0]    mem_wdata_q, mem_wdata_d;
  logic                swap_q, swap_d;
  logic [7:0]          frames_q, frames_d;
  logic [c_addr_w:0]   clr_off;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_CLEAR;
      front_q     <= 1'b0;
      cnt_q       <= '0;
      mem_wen_q   <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      swap_q      <= 1'b0;
      frames_q    <= '0;
    end else begin
      state_q     <= state_d;
      front_q     <= front_d;
      cnt_q       <= cnt_d;
      mem_wen_q   <= mem_wen_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdata_q <= mem_wdata_d;
      swap_q      <= swap_d;
      frames_q    <= frames_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    front_d     = front_q;
    cnt_d       = cnt_q;
    mem_wen_d   = 1'b0;
    mem_waddr_d = mem_waddr_q;
    mem_wdata_d = mem_wdata_q;
    swap_d      = 1'b0;
    frames_d    = frames_q;
    clr_off     = cnt_q - c_chan;
    unique case (state_q)
      ST_CLEAR: begin
        // Linear counter folded onto {bank, addr} so non-power-of-two
        // channel counts still clear exactly addr < c_channels per bank.
        mem_wen_d   = 1'b1;
        mem_wdata_d = '0;
        if (cnt_q < c_chan) mem_waddr_d = {1'b0, cnt_q[c_addr_w-1:0]};
        else                mem_waddr_d = {1'b1, clr_off[c_addr_w-1:0]};
        cnt_d = cnt_q + c_one;
        if (cnt_q == c_last) begin
          cnt_d   = '0;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (i_wr_valid) begin
          mem_wen_d   = ({1'b0, i_wr_addr} < c_chan);
          mem_waddr_d = {~front_q, i_wr_addr};
          mem_wdata_d = i_wr_data;
        end
        if (i_commit) state_d = ST_PENDING;
      end
      ST_PENDING: begin
        if (i_drv_drq) begin
          front_d  = ~front_q;
          frames_d = frames_q + 8'd1;
          swap_d   = 1'b1;
          state_d  = ST_WRITE;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  assign o_wr_ready  = (state_q == ST_WRITE);
  assign o_pending   = (state_q == ST_PENDING);
  assign o_mem_wen   = mem_wen_q;
  assign o_mem_waddr = mem_waddr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_ren   = i_drv_read;
  assign o_mem_raddr = {front_q, i_drv_addr};
  assign o_swap      = swap_q;
  assign o_frames    = frames_q;

endmodule

// File: tb/tb_fb_swap_ctrl.sv
// Directed bench for fb_swap_ctrl: clear sequence, swap handshake, ignored
// commits/requests, frame counter wrap, reset abort, out-of-range writes.
module tb_fb_swap_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid, commit, drq, drv_read;
  logic [5:0]  wr_addr, drv_addr;
  logic [11:0] wr_data;
  logic        wr_ready, pending, mem_wen, mem_ren, swap;
  logic [6:0]  mem_waddr, mem_raddr;
  logic [11:0] mem_wdata;
  logic [7:0]  frames;

  logic        wr_valid3;
  logic [6:0]  wr_addr3;
  logic [11:0] wr_data3;
  logic        wr_ready3, pending3, mem_wen3, mem_ren3, swap3;
  logic [7:0]  mem_waddr3, mem_raddr3;
  logic [11:0] mem_wdata3;
  logic [7:0]  frames3;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  fb_swap_ctrl #(.c_ledboards(2), .c_bps(12)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
    .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_commit(commit), .o_pending(pending),
    .i_drv_drq(drq), .i_drv_read(drv_read), .i_drv_addr(drv_addr),
    .o_mem_wen(mem_wen), .o_mem_waddr(mem_waddr), .o_mem_wdata(mem_wdata),
    .o_mem_ren(mem_ren), .o_mem_raddr(mem_raddr),
    .o_swap(swap), .o_frames(frames)
  );

  fb_swap_ctrl #(.c_ledboards(3), .c_bps(12)) u_dut3 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wr_valid(wr_valid3), .o_wr_ready(wr_ready3),
    .i_wr_addr(wr_addr3), .i_wr_data(wr_data3),
    .i_commit(1'b0), .o_pending(pending3),
    .i_drv_drq(1'b0), .i_drv_read(1'b0), .i_drv_addr(7'd0),
    .o_mem_wen(mem_wen3), .o_mem_waddr(mem_waddr3), .o_mem_wdata(mem_wdata3),
    .o_mem_ren(mem_ren3), .o_mem_raddr(mem_raddr3),
    .o_swap(swap3), .o_frames(frames3)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [6:0] idx;
    rst_n = 1'b0; wr_valid = 1'b0; commit = 1'b0; drq = 1'b0; drv_read = 1'b0;
    wr_addr = '0; drv_addr = 6'd3; wr_data = '0;
    wr_valid3 = 1'b0; wr_addr3 = '0; wr_data3 = '0;
    #1;
    check_eq("rst_ready",  32'(wr_ready), 32'd0);
    check_eq("rst_pend",   32'(pending), 32'd0);
    check_eq("rst_wen",    32'(mem_wen), 32'd0);
    check_eq("rst_waddr",  32'(mem_waddr), 32'd0);
    check_eq("rst_wdata",  32'(mem_wdata), 32'd0);
    check_eq("rst_swap",   32'(swap), 32'd0);
    check_eq("rst_frames", 32'(frames), 32'd0);
    check_eq("rst_raddr",  32'(mem_raddr), 32'd3);
    drv_read = 1'b1;
    #1;
    check_eq("rst_ren", 32'(mem_ren), 32'd1);

    // Clear: source writes and a commit are offered but must be ignored.
    tick();
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    wr_valid = 1'b1; wr_addr = 6'd5; wr_data = 12'h123;
    for (int i = 0; i < 128; i++) begin
      if (i == 10) commit = 1'b1;
      if (i == 11) commit = 1'b0;
      if (i == 20) wr_valid = 1'b0;
      tick();
      idx = 7'(i);
      check_eq("clear", {11'd0, wr_ready, mem_wen, mem_waddr, mem_wdata},
               {11'd0, (i == 127), 1'b1, idx, 12'h000});
    end
    check_eq("clr_no_pend", 32'(pending), 32'd0);
    tick();
    check_eq("post_clr_wen", 32'(mem_wen), 32'd0);

    // Write channel 5, commit, request.
    wr_valid = 1'b1; wr_addr = 6'd5; wr_data = 12'hABC;
    tick();
    wr_valid = 1'b0;
    check_eq("wr_wen",   32'(mem_wen), 32'd1);
    check_eq("wr_waddr", 32'(mem_waddr), 32'd69);
    check_eq("wr_wdata", 32'(mem_wdata), 32'hABC);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    check_eq("cm_pend",  32'(pending), 32'd1);
    check_eq("cm_ready", 32'(wr_ready), 32'd0);
    drq = 1'b1; drv_addr = 6'd5;
    #1;
    check_eq("drq_old_bank", 32'(mem_raddr), 32'd5);
    tick();
    drq = 1'b0;
    check_eq("sw_pulse",  32'(swap), 32'd1);
    check_eq("sw_frames", 32'(frames), 32'd1);
    check_eq("sw_raddr",  32'(mem_raddr), 32'd69);
    check_eq("sw_ready",  32'(wr_ready), 32'd1);
    tick();
    check_eq("sw_once", 32'(swap), 32'd0);

    // Requests without a commit repeat the current front bank.
    for (int i = 0; i < 3; i++) begin
      drq = 1'b1;
      tick();
      drq = 1'b0;
      check_eq("nc_swap", 32'(swap), 32'd0);
    end
    check_eq("nc_frames", 32'(frames), 32'd1);
    check_eq("nc_raddr",  32'(mem_raddr), 32'd69);

    // Second commit while pending is ignored.
    commit = 1'b1;
    tick();
    check_eq("cp_ready", 32'(wr_ready), 32'd0);
    tick();
    commit = 1'b0;
    check_eq("cp_pend", 32'(pending), 32'd1);
    drq = 1'b1;
    tick();
    drq = 1'b0;
    check_eq("cp_frames", 32'(frames), 32'd2);
    drq = 1'b1;
    tick();
    drq = 1'b0;
    check_eq("cp_one_swap", 32'(frames), 32'd2);
    check_eq("cp_raddr",    32'(mem_raddr), 32'd5);

    // Write together with commit, request on the very next cycle.
    wr_valid = 1'b1; wr_addr = 6'd7; wr_data = 12'h5A5; commit = 1'b1;
    tick();
    wr_valid = 1'b0; commit = 1'b0; drq = 1'b1;
    check_eq("wc_waddr", 32'(mem_waddr), 32'd71);
    check_eq("wc_wen",   32'(mem_wen), 32'd1);
    tick();
    drq = 1'b0; drv_addr = 6'd7;
    #1;
    check_eq("wc_frames", 32'(frames), 32'd3);
    check_eq("wc_raddr",  32'(mem_raddr), 32'd71);

    // Counter wrap: 253 more swaps reach 256 total.
    for (int n = 0; n < 253; n++) begin
      commit = 1'b1;
      tick();
      commit = 1'b0; drq = 1'b1;
      tick();
      drq = 1'b0;
    end
    check_eq("wrap_frames", 32'(frames), 32'd0);
    check_eq("wrap_raddr",  32'(mem_raddr), 32'd7);

    // Reset while pending with bank 1 in front.
    commit = 1'b1;
    tick();
    commit = 1'b0; drq = 1'b1;
    tick();
    drq = 1'b0; drv_addr = 6'd9;
    #1;
    check_eq("pre_rst_raddr", 32'(mem_raddr), 32'd73);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    check_eq("pre_rst_pend", 32'(pending), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_pend",   32'(pending), 32'd0);
    check_eq("mid_rst_raddr",  32'(mem_raddr), 32'd9);
    check_eq("mid_rst_frames", 32'(frames), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    tick();
    check_eq("reclear", {30'd0, mem_wen, wr_ready}, {30'd0, 1'b1, 1'b0});
    check_eq("reclear_addr", 32'(mem_waddr), 32'd0);

    // Three-board instance: out-of-range write is consumed silently.
    for (int i = 0; i < 200; i++) tick();
    check_eq("b3_ready", 32'(wr_ready3), 32'd1);
    wr_valid3 = 1'b1; wr_addr3 = 7'd100; wr_data3 = 12'h111;
    tick();
    check_eq("b3_oob_wen",   32'(mem_wen3), 32'd0);
    check_eq("b3_oob_ready", 32'(wr_ready3), 32'd1);
    wr_addr3 = 7'd95;
    tick();
    wr_valid3 = 1'b0;
    check_eq("b3_wen",   32'(mem_wen3), 32'd1);
    check_eq("b3_waddr", 32'(mem_waddr3), 32'd223);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fb_swap_ctrl.md
# fb_swap_ctrl

Double-buffer controller for the LED framebuffer. It sits between a frame source (host loader), the driver's read side and a framebuffer instance sized for two banks of `c_channels` entries. It steers source writes into the back bank and the driver's reads to the front bank. On a committed frame it swaps the banks exactly at the driver's frame request, so every frame the driver shifts out comes from a single bank. After reset it zero-fills both banks.

## Interface
Parameters:
- `c_ledboards`, default 2: number of LED boards; `c_channels = c_ledboards*32`, `c_addr_w = $clog2(c_channels)`.
- `c_bps`, default 12: bits per channel.

Ports:
- `i_clk` in 1: system clock; one clock domain for the whole block.
- `i_rst_n` in 1: reset; asynchronous, active-low.
- `i_wr_valid` in 1: source has a channel write.
- `o_wr_ready` out 1: write accepted when `i_wr_valid && o_wr_ready`.
- `i_wr_addr` in `c_addr_w`: channel index.
- `i_wr_data` in `c_bps`: channel value.
- `i_commit` in 1: one-cycle pulse, back bank complete.
- `o_pending` out 1: commit waiting for the next frame request.
- `i_drv_drq` in 1: one-cycle pulse from driver at frame start.
- `i_drv_read` in 1: driver read enable.
- `i_drv_addr` in `c_addr_w`: driver read address.
- `o_mem_wen` out 1: framebuffer write enable.
- `o_mem_waddr` out `c_addr_w+1`: {bank, addr}.
- `o_mem_wdata` out `c_bps`: write data.
- `o_mem_ren` out 1: framebuffer read enable.
- `o_mem_raddr` out `c_addr_w+1`: {bank, addr}.
- `o_swap` out 1: one-cycle pulse, the cycle after a swap.
- `o_frames` out 8: swap count, wraps 255→0.

## Operation
- The block has three states: CLEAR, WRITE and PENDING. Reset enters CLEAR.
- CLEAR:
  - A counter runs 0 … 2·c_channels−1, writing 0 to every {bank, addr} with addr < c_channels.
  - `o_wr_ready=0`. `i_commit` is ignored.
  - After the last entry the block moves to WRITE.
- WRITE:
  - `o_wr_ready=1`.
  - An accepted write goes to bank `~r_front`.
  - An accepted write with `i_wr_addr >= c_channels` is consumed but produces no `o_mem_wen`.
  - `i_commit` moves the block to PENDING. A write accepted in the same cycle as the commit belongs to the committed frame.
- PENDING:
  - `o_wr_ready=0`, `o_pending=1`.
  - On `i_drv_drq`, `r_front` toggles, `o_frames` increments, `o_swap` pulses and the block returns to WRITE.
  - Further commits are ignored.
- `i_drv_drq` in WRITE or CLEAR: no swap; the driver repeats the current front bank.
- Read path: `o_mem_ren = i_drv_read` and `o_mem_raddr = {r_front, i_drv_addr}`, both combinational. A read in the same cycle as a swapping `i_drv_drq` uses the old bank.
- Async reset at any point, including mid-clear or mid-pending, aborts everything:
  - Next state is CLEAR, `r_front=0`, counter=0.
  - An uncommitted frame is lost.
- Reset values:
  - `o_wr_ready=0`, `o_pending=0`, `o_mem_wen=0`, `o_mem_waddr=0`, `o_mem_wdata=0`.
  - `o_swap=0`, `o_frames=0`.
  - `o_mem_ren` and `o_mem_raddr` follow their inputs with `r_front=0`.

## Timing
- Write path is registered. A handshake accepted at edge t drives `o_mem_wen`, `o_mem_waddr` and `o_mem_wdata` during cycle t+1, and the framebuffer writes at edge t+1.
- The write bank is captured at accept time. A write accepted together with the commit, followed by `i_drv_drq` one cycle later, still lands in the bank that becomes the front bank.
- Commit latency: `o_pending` is high starting the cycle after `i_commit`.
- Swap: `r_front` changes at the edge sampling `i_drv_drq`. `o_swap` and the new `o_frames` value appear in the same following cycle.
- Clear duration is exactly 2·c_channels cycles after reset release. With defaults that is 128 cycles, with `o_wr_ready` rising in cycle 128.
- There is no back-pressure on the read path: read data returns with the framebuffer's own read latency.

## Structure
- Shared package `lamp_pkg` holds:
  - `c_leds_per_board = 32`.
  - The state enum (CLEAR, WRITE, PENDING).
  - Channel-count and address-width helper functions also used by the framebuffer and driver.
- The framebuffer is instantiated outside this block with 2·c_channels depth.
- No sub-module is needed; the clear counter and FSM are kept inline.

## Test plan
- **Reset clear:** release `i_rst_n` → 128 consecutive `o_mem_wen` with data 0, addresses 0–63 then 64–127; `o_wr_ready` rises in cycle 128.
- **Write/commit/swap:** write channel 5 = 0xABC, commit, pulse drq → write lands at waddr 69 (bank 1); after drq, a read of addr 5 hits raddr 69; `o_swap` pulses once; `o_frames=1`.
- **Drq without commit:**
  - 3 drq pulses in WRITE → `r_front` unchanged, `o_swap` stays 0, `o_frames` unchanged.
  - Writes/commits in CLEAR are ignored.
- **Commit in PENDING:** 2nd commit before drq → ignored, `o_wr_ready=0`; 1 swap only.
- **Edge cases:**
  - Write and commit in the same cycle, drq next cycle → the write lands in the new front bank.
  - With `c_ledboards=3`, a write to addr 100 → accepted, no `o_mem_wen`.
  - 256 swaps → `o_frames` wraps to 0.
- **Reset mid-PENDING:** assert `i_rst_n=0` → `o_pending=0` and `r_front=0` immediately; clear restarts.
